// File: rtl/pwm_multichannel.sv
// Multichannel PWM generator: one shared edge- or center-aligned counter drives
// CHANNELS comparators, with shadowed settings that only change at period boundaries.
module pwm_multichannel #(
    parameter int BIT_WIDTH = 10,
    parameter int CHANNELS  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [BIT_WIDTH-1:0]          max_value,
    input  logic                          center_mode,
    input  logic [CHANNELS*BIT_WIDTH-1:0] duty,
    input  logic                          load,
    output logic                          load_ack,
    output logic [CHANNELS-1:0]           pwm_out,
    output logic                          period_start
);

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_t;

    localparam logic [BIT_WIDTH-1:0] ONE       = BIT_WIDTH'(1);
    localparam logic [BIT_WIDTH-1:0] RESET_MAX = {{(BIT_WIDTH-1){1'b1}}, 1'b0};

    logic [BIT_WIDTH-1:0] cnt;
    logic [BIT_WIDTH-1:0] cnt_next;
    logic [BIT_WIDTH-1:0] max_act;
    logic                 mode_act;
    logic [BIT_WIDTH-1:0] duty_act [CHANNELS];
    dir_t                 dir;
    dir_t                 dir_next;
    logic                 pending;
    logic                 boundary;
    logic                 update;

    // The last cycle of a period is the only place the shadows may change,
    // except while stopped, where any cycle is safe.
    always_comb begin
        boundary = mode_act ? (dir == DIR_DOWN && cnt == '0) : (cnt == max_act);
        update   = (pending | load) && (boundary || !enable);
        cnt_next = cnt;
        dir_next = dir;
        if (update || !enable) begin
            cnt_next = '0;
            dir_next = DIR_UP;
        end else if (!mode_act) begin
            cnt_next = (cnt == max_act) ? '0 : cnt + ONE;
        end else if (dir == DIR_UP) begin
            if (cnt == max_act)
                dir_next = DIR_DOWN;
            else
                cnt_next = cnt + ONE;
        end else begin
            if (cnt == '0)
                dir_next = DIR_UP;
            else
                cnt_next = cnt - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            dir          <= DIR_UP;
            pending      <= 1'b0;
            mode_act     <= 1'b0;
            max_act      <= RESET_MAX;
            load_ack     <= 1'b0;
            pwm_out      <= '0;
            period_start <= 1'b0;
            for (int i = 0; i < CHANNELS; i++)
                duty_act[i] <= '0;
        end else begin
            cnt      <= cnt_next;
            dir      <= dir_next;
            pending  <= (pending | load) & ~update;
            load_ack <= update;
            if (update) begin
                max_act  <= max_value;
                mode_act <= center_mode;
                for (int i = 0; i < CHANNELS; i++)
                    duty_act[i] <= duty[i*BIT_WIDTH +: BIT_WIDTH];
            end
            // Outputs compare the current count, so they lag cnt by exactly one cycle.
            period_start <= enable && (cnt == '0) && (dir == DIR_UP);
            for (int i = 0; i < CHANNELS; i++)
                pwm_out[i] <= enable && (cnt < duty_act[i]);
        end
    end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed bench for pwm_multichannel: a 10-bit, 4-channel instance for the main
// scenarios and a 4-bit, 2-channel instance for the full-range period case.
module tb_pwm_multichannel;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [9:0]  max_value;
    logic        center_mode;
    logic [39:0] duty;
    logic        load;
    logic        load_ack;
    logic [3:0]  pwm_out;
    logic        period_start;

    logic        s_enable;
    logic [3:0]  s_max;
    logic        s_center;
    logic [7:0]  s_duty;
    logic        s_load;
    logic        s_ack;
    logic [1:0]  s_pwm;
    logic        s_ps;

    int          errors;
    int          checks;
    int          hi [4];
    int          ps_cnt;
    int          ack_cnt;
    logic [31:0] mask [4];

    pwm_multichannel #(.BIT_WIDTH(10), .CHANNELS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .max_value    (max_value),
        .center_mode  (center_mode),
        .duty         (duty),
        .load         (load),
        .load_ack     (load_ack),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    pwm_multichannel #(.BIT_WIDTH(4), .CHANNELS(2)) dut_small (
        .clk          (clk),
        .rst          (rst),
        .enable       (s_enable),
        .max_value    (s_max),
        .center_mode  (s_center),
        .duty         (s_duty),
        .load         (s_load),
        .load_ack     (s_ack),
        .pwm_out      (s_pwm),
        .period_start (s_ps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task step;
        @(posedge clk);
        #1;
    endtask

    task set_duty(input logic [9:0] d0, input logic [9:0] d1, input logic [9:0] d2, input logic [9:0] d3);
        duty = {d3, d2, d1, d0};
    endtask

    // Records len samples starting at the current one; any load pulse lasts one edge.
    task capture(input int len);
        for (int ch = 0; ch < 4; ch++) begin
            hi[ch]   = 0;
            mask[ch] = '0;
        end
        ps_cnt  = 0;
        ack_cnt = 0;
        for (int k = 0; k < len; k++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (pwm_out[ch]) begin
                    hi[ch]++;
                    if (k < 32) mask[ch][k] = 1'b1;
                end
            end
            if (period_start) ps_cnt++;
            if (load_ack) ack_cnt++;
            step;
            load = 1'b0;
        end
    endtask

    task wait_ps(input string name);
        int n;
        n = 0;
        while (!period_start && n < 100) begin
            step;
            load = 1'b0;
            n++;
        end
        checks++;
        if (period_start !== 1'b1) begin
            errors++;
            $display("FAIL %s: period_start never seen, got %b expected 1", name, period_start);
        end
    endtask

    task test_reset;
        rst = 1'b1; enable = 1'b0; load = 1'b0; max_value = '0; center_mode = 1'b0; duty = '0;
        s_enable = 1'b0; s_load = 1'b0; s_max = '0; s_center = 1'b0; s_duty = '0;
        step;
        step;
        checks++; if (pwm_out !== 4'b0) begin errors++; $display("FAIL reset_pwm: got %b expected 0000", pwm_out); end
        checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL reset_ps: got %b expected 0", period_start); end
        checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", load_ack); end
        checks++; if (s_pwm !== 2'b0) begin errors++; $display("FAIL reset_small_pwm: got %b expected 00", s_pwm); end
        rst = 1'b0;
        step;
    endtask

    task test_edge;
        max_value = 10'd9; center_mode = 1'b0; set_duty(10'd0, 10'd3, 10'd9, 10'd10);
        load = 1'b1;
        step;
        load = 1'b0;
        checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL edge_load_ack: got %b expected 1", load_ack); end
        enable = 1'b1;
        wait_ps("edge_first_ps");
        capture(10);
        checks++; if (hi[0] != 0) begin errors++; $display("FAIL edge_high_ch0: got %0d expected 0", hi[0]); end
        checks++; if (hi[1] != 3) begin errors++; $display("FAIL edge_high_ch1: got %0d expected 3", hi[1]); end
        checks++; if (hi[2] != 9) begin errors++; $display("FAIL edge_high_ch2: got %0d expected 9", hi[2]); end
        checks++; if (hi[3] != 10) begin errors++; $display("FAIL edge_high_ch3: got %0d expected 10", hi[3]); end
        checks++; if (mask[1] !== 32'h7) begin errors++; $display("FAIL edge_ch1_shape: got %h expected 00000007", mask[1]); end
        checks++; if (ps_cnt != 1) begin errors++; $display("FAIL edge_ps_count: got %0d expected 1", ps_cnt); end
        checks++; if (ack_cnt != 0) begin errors++; $display("FAIL edge_extra_ack: got %0d expected 0", ack_cnt); end
        checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL edge_period10: got %b expected 1", period_start); end
    endtask

    task test_mid_period_load;
        set_duty(10'd3, 10'd3, 10'd9, 10'd10);
        load = 1'b1;
        capture(10);
        checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL mid_prep_ps: got %b expected 1", period_start); end
        set_duty(10'd7, 10'd3, 10'd9, 10'd10);
        load = 1'b1;
        capture(10);
        checks++; if (mask[0] !== 32'h7) begin errors++; $display("FAIL mid_old_duty: got %h expected 00000007", mask[0]); end
        checks++; if (ack_cnt != 1) begin errors++; $display("FAIL mid_ack_count: got %0d expected 1", ack_cnt); end
        checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL mid_new_ps: got %b expected 1", period_start); end
        capture(10);
        checks++; if (mask[0] !== 32'h7F) begin errors++; $display("FAIL mid_new_duty: got %h expected 0000007f", mask[0]); end
        checks++; if (ps_cnt != 1) begin errors++; $display("FAIL mid_ps_count: got %0d expected 1", ps_cnt); end
    endtask

    task test_center;
        center_mode = 1'b1; max_value = 10'd9; set_duty(10'd7, 10'd3, 10'd9, 10'd10);
        load = 1'b1;
        capture(10);
        checks++; if (ack_cnt != 1) begin errors++; $display("FAIL center_ack: got %0d expected 1", ack_cnt); end
        checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL center_first_ps: got %b expected 1", period_start); end
        capture(20);
        checks++; if (mask[1] !== 32'h000E0007) begin errors++; $display("FAIL center_ch1_shape: got %h expected 000e0007", mask[1]); end
        checks++; if (hi[1] != 6) begin errors++; $display("FAIL center_high_ch1: got %0d expected 6", hi[1]); end
        checks++; if (hi[0] != 14) begin errors++; $display("FAIL center_high_ch0: got %0d expected 14", hi[0]); end
        checks++; if (hi[2] != 18) begin errors++; $display("FAIL center_high_ch2: got %0d expected 18", hi[2]); end
        checks++; if (hi[3] != 20) begin errors++; $display("FAIL center_high_ch3: got %0d expected 20", hi[3]); end
        checks++; if (ps_cnt != 1) begin errors++; $display("FAIL center_ps_count: got %0d expected 1", ps_cnt); end
        checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL center_period20: got %b expected 1", period_start); end
    endtask

    task test_back_to_back;
        // From a center-mode period_start sample the boundary cycle is 18 cycles later.
        for (int k = 0; k < 18; k++) step;
        checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL boundary_pre_ack: got %b expected 0", load_ack); end
        center_mode = 1'b0; max_value = 10'd9; set_duty(10'd7, 10'd3, 10'd9, 10'd10);
        load = 1'b1;
        step;
        load = 1'b0;
        checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL boundary_ack: got %b expected 1", load_ack); end
        step;
        checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL boundary_ack_single: got %b expected 0", load_ack); end
        checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL boundary_ps: got %b expected 1", period_start); end
        load = 1'b1;
        step;
        load = 1'b0;
        step;
        load = 1'b1;
        capture(20);
        checks++; if (ack_cnt != 1) begin errors++; $display("FAIL double_load_acks: got %0d expected 1", ack_cnt); end
    endtask

    task test_reset_pending;
        wait_ps("rst_align_ps");
        load = 1'b1;
        step;
        load = 1'b0;
        rst = 1'b1;
        step;
        checks++; if (pwm_out !== 4'b0) begin errors++; $display("FAIL rst_mid_pwm: got %b expected 0000", pwm_out); end
        checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL rst_mid_ps: got %b expected 0", period_start); end
        checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL rst_mid_ack: got %b expected 0", load_ack); end
        rst = 1'b0;
        capture(40);
        checks++; if (hi[0] + hi[1] + hi[2] + hi[3] != 0) begin errors++; $display("FAIL rst_duty0_low: got %0d high samples expected 0", hi[0] + hi[1] + hi[2] + hi[3]); end
        checks++; if (ack_cnt != 0) begin errors++; $display("FAIL rst_no_ack: got %0d expected 0", ack_cnt); end
        checks++; if (ps_cnt != 1) begin errors++; $display("FAIL rst_ps_count: got %0d expected 1", ps_cnt); end
        enable = 1'b0;
        step;
        checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL rst_pending_discarded: got %b expected 0", load_ack); end
    endtask

    task test_disable_load;
        max_value = 10'd9; center_mode = 1'b0; set_duty(10'd0, 10'd3, 10'd9, 10'd10);
        load = 1'b1;
        step;
        load = 1'b0;
        checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL disabled_ack: got %b expected 1", load_ack); end
        checks++; if (pwm_out !== 4'b0) begin errors++; $display("FAIL disabled_pwm: got %b expected 0000", pwm_out); end
        checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL disabled_ps: got %b expected 0", period_start); end
        step;
        checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL disabled_ack_single: got %b expected 0", load_ack); end
    endtask

    task test_full_range;
        int n;
        int h0;
        int h1;
        int pc;
        s_max = 4'd15; s_center = 1'b0; s_duty = {4'd8, 4'd15};
        s_load = 1'b1;
        step;
        s_load = 1'b0;
        checks++; if (s_ack !== 1'b1) begin errors++; $display("FAIL small_ack: got %b expected 1", s_ack); end
        s_enable = 1'b1;
        n = 0;
        while (!s_ps && n < 100) begin step; n++; end
        checks++; if (s_ps !== 1'b1) begin errors++; $display("FAIL small_first_ps: got %b expected 1", s_ps); end
        h0 = 0; h1 = 0; pc = 0;
        for (int k = 0; k < 16; k++) begin
            if (s_pwm[0]) h0++;
            if (s_pwm[1]) h1++;
            if (s_ps) pc++;
            step;
        end
        checks++; if (h0 != 15) begin errors++; $display("FAIL small_high_ch0: got %0d expected 15", h0); end
        checks++; if (h1 != 8) begin errors++; $display("FAIL small_high_ch1: got %0d expected 8", h1); end
        checks++; if (pc != 1) begin errors++; $display("FAIL small_ps_count: got %0d expected 1", pc); end
        checks++; if (s_ps !== 1'b1) begin errors++; $display("FAIL small_period16: got %b expected 1", s_ps); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset;
        test_edge;
        test_mid_period_load;
        test_center;
        test_back_to_back;
        test_reset_pending;
        test_disable_load;
        test_full_range;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
